// File: rtl/cpu_exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_exec_pkg
// Description : Shared types for the execution core: opcode, addressing
//               mode and FSM state encodings, status flag bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_exec_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_LDX = 4'h1,
    OP_STA = 4'h2,
    OP_STX = 4'h3,
    OP_ADC = 4'h4,
    OP_SBC = 4'h5,
    OP_AND = 4'h6,
    OP_ORA = 4'h7,
    OP_EOR = 4'h8,
    OP_CMP = 4'h9,
    OP_INX = 4'hA,
    OP_DEX = 4'hB,
    OP_TAX = 4'hC,
    OP_TXA = 4'hD,
    OP_FLG = 4'hE,
    OP_NOP = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    MODE_IMM     = 2'd0,
    MODE_ABS     = 2'd1,
    MODE_ABS_IDX = 2'd2,
    MODE_RSV     = 2'd3
  } mode_e;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_FIX  = 3'd1,
    ST_MEM  = 3'd2,
    ST_EXEC = 3'd3
  } state_e;

  // Status register bit positions (6502 layout)
  localparam int c_flag_c = 0;
  localparam int c_flag_z = 1;
  localparam int c_flag_d = 3;
  localparam int c_flag_v = 6;
  localparam int c_flag_n = 7;

  // Ops that never touch the bus regardless of addressing mode
  function automatic logic is_reg_op(input op_e op);
    return (op == OP_INX) || (op == OP_DEX) || (op == OP_TAX) ||
           (op == OP_TXA) || (op == OP_FLG) || (op == OP_NOP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_exec_alu.sv
`default_nettype none
// ============================================================================
// Module      : cpu_exec_alu
// Description : Combinational add/subtract unit for ADC, SBC and CMP.
//               Produces the binary sum (used for Z/N/V) and the value to
//               write back, which differs only on the BCD path.
//               Optional macro CPU_DECIMAL_EN enables NMOS-style decimal
//               adjust when DATA_W == 8; otherwise arithmetic is binary.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_exec_alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_cin,
  input  logic              i_sub,
  input  logic              i_dec,
  output logic [DATA_W-1:0] o_result,
  output logic [DATA_W-1:0] o_bin_result,
  output logic              o_c,
  output logic              o_v
);

  logic [DATA_W-1:0] w_bop;
  logic [DATA_W:0]   w_sum;

  // Binary adder; subtraction is A + ~B + C as on the original part
  always_comb begin
    w_bop = i_sub ? ~i_b : i_b;
    w_sum = {1'b0, i_a} + {1'b0, w_bop} + {{DATA_W{1'b0}}, i_cin};
  end

  assign o_bin_result = w_sum[DATA_W-1:0];
  assign o_v = (i_a[DATA_W-1] == w_bop[DATA_W-1]) &&
               (w_sum[DATA_W-1] != i_a[DATA_W-1]);

`ifdef CPU_DECIMAL_EN
  if (DATA_W == 8) begin : g_bcd
    logic [4:0] w_alo;
    logic [5:0] w_ahi;
    logic [4:0] w_slo;
    logic [4:0] w_shi;
    logic       w_sborrow;

    // Per-nibble decimal adjust for both add and subtract
    always_comb begin
      w_alo = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]} + {4'b0, i_cin};
      if (w_alo > 5'd9) w_alo = w_alo + 5'd6;
      w_ahi = {2'b0, i_a[7:4]} + {2'b0, i_b[7:4]} + {5'b0, w_alo[4]};
      if (w_ahi > 6'd9) w_ahi = w_ahi + 6'd6;

      w_slo = {1'b0, i_a[3:0]} - {1'b0, i_b[3:0]} - {4'b0, ~i_cin};
      w_sborrow = w_slo[4];
      if (w_sborrow) w_slo = w_slo - 5'd6;
      w_shi = {1'b0, i_a[7:4]} - {1'b0, i_b[7:4]} - {4'b0, w_sborrow};
      if (w_shi[4]) w_shi = w_shi - 5'd6;
    end

    assign o_result = !i_dec ? w_sum[DATA_W-1:0] :
                      (i_sub ? {w_shi[3:0], w_slo[3:0]} : {w_ahi[3:0], w_alo[3:0]});
    // Decimal borrow on subtract coincides with the binary carry
    assign o_c = (i_dec && !i_sub) ? (w_ahi[5:4] != 2'b00) : w_sum[DATA_W];
  end else begin : g_nobcd
    logic w_dec_unused;
    assign w_dec_unused = i_dec;
    assign o_result     = w_sum[DATA_W-1:0];
    assign o_c          = w_sum[DATA_W];
  end
`else
  logic w_dec_unused;
  assign w_dec_unused = i_dec;
  assign o_result     = w_sum[DATA_W-1:0];
  assign o_c          = w_sum[DATA_W];
`endif

endmodule
`default_nettype wire

// File: rtl/cpu_exec_core.sv
`default_nettype none
// ============================================================================
// Module      : cpu_exec_core
// Description : Single-clock micro-op execution core with accumulator,
//               NUM_IDX index registers and status P. Accepts one micro-op
//               at a time from the sequencer, performs at most one memory
//               bus cycle (with index-carry fix-up) and writes back on EXEC.
//               Optional macro CPU_DECIMAL_EN enables BCD ADC/SBC.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_exec_core #(
  parameter  int DATA_W  = 8,
  parameter  int ADDR_W  = 16,
  parameter  int NUM_IDX = 2,
  localparam int IDX_W   = (NUM_IDX > 1) ? $clog2(NUM_IDX) : 1
) (
  input  logic                      clk_ph1,
  input  logic                      rst,
  input  logic                      uop_valid,
  output logic                      uop_ready,
  input  logic [3:0]                uop_op,
  input  logic [1:0]                uop_mode,
  input  logic [IDX_W-1:0]          uop_reg,
  input  logic [IDX_W-1:0]          uop_ireg,
  input  logic [ADDR_W-1:0]         uop_operand,
  output logic                      done_valid,
  output logic                      mem_req,
  output logic                      mem_r_nw,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_rdy,
  output logic [DATA_W-1:0]         ac_dbg,
  output logic [7:0]                p_dbg,
  output logic [NUM_IDX*DATA_W-1:0] idx_dbg,
  output logic [2:0]                state_dbg
);
  import cpu_exec_pkg::*;

  localparam int c_hi_w = ADDR_W - DATA_W;

  state_e              r_state;
  state_e              w_state_next;
  logic [DATA_W-1:0]   r_ac;
  logic [DATA_W-1:0]   r_idx [NUM_IDX];
  logic [7:0]          r_p;
  op_e                 r_op;
  mode_e               r_mode;
  logic [IDX_W-1:0]    r_reg;
  logic [DATA_W-1:0]   r_imm;
  logic                r_is_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_mdata;
  logic                r_done;

  // Incoming micro-op decode
  op_e                 w_in_op;
  mode_e               w_in_mode;
  logic                w_in_store;
  logic                w_in_bus;
  logic                w_in_carry;
  logic [DATA_W:0]     w_lo_sum;
  logic [ADDR_W-1:0]   w_in_addr;
  logic                w_accept;
  logic [DATA_W-1:0]   w_ireg_val;
  logic [DATA_W-1:0]   w_sreg_val;
  logic [DATA_W-1:0]   w_reg_val;

  // Execute stage
  logic [DATA_W-1:0]   w_b;
  logic                w_alu_cin;
  logic                w_alu_sub;
  logic                w_alu_dec;
  logic [DATA_W-1:0]   w_alu_res;
  logic [DATA_W-1:0]   w_alu_bin;
  logic                w_alu_c;
  logic                w_alu_v;
  logic                w_ac_we;
  logic [DATA_W-1:0]   w_ac_new;
  logic                w_idx_we;
  logic [DATA_W-1:0]   w_idx_new;
  logic [7:0]          w_p_new;
  logic                w_zn_we;
  logic [DATA_W-1:0]   w_zn_val;

  assign w_in_op    = op_e'(uop_op);
  assign w_in_mode  = mode_e'(uop_mode);
  assign w_accept   = uop_valid && (r_state == ST_IDLE);
  assign w_in_store = (w_in_op == OP_STA) || (w_in_op == OP_STX);
  assign w_in_bus   = !is_reg_op(w_in_op) && (w_in_mode != MODE_IMM);

  // Index register read ports: indexing base, store source, execute source
  always_comb begin
    w_ireg_val = '0;
    w_sreg_val = '0;
    w_reg_val  = '0;
    for (int i = 0; i < NUM_IDX; i++) begin
      if (i == int'(uop_ireg)) w_ireg_val = r_idx[i];
      if (i == int'(uop_reg))  w_sreg_val = r_idx[i];
      if (i == int'(r_reg))    w_reg_val  = r_idx[i];
    end
  end

  // Effective address; a carry out of the low byte defers the high-part bump to FIX
  always_comb begin
    w_lo_sum   = {1'b0, uop_operand[DATA_W-1:0]} + {1'b0, w_ireg_val};
    w_in_carry = (w_in_mode == MODE_ABS_IDX) && w_lo_sum[DATA_W];
    if (w_in_mode == MODE_ABS_IDX)
      w_in_addr = {uop_operand[ADDR_W-1:DATA_W], w_lo_sum[DATA_W-1:0]};
    else
      w_in_addr = uop_operand;
  end

  // FSM state register
  always_ff @(posedge clk_ph1) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // FSM next state and bus handshake outputs
  always_comb begin
    w_state_next = r_state;
    uop_ready    = 1'b0;
    mem_req      = 1'b0;
    mem_r_nw     = 1'b1;
    case (r_state)
      ST_IDLE: begin
        uop_ready = 1'b1;
        if (w_accept) begin
          if (!w_in_bus)       w_state_next = ST_EXEC;
          else if (w_in_carry) w_state_next = ST_FIX;
          else                 w_state_next = ST_MEM;
        end
      end
      ST_FIX: w_state_next = ST_MEM;
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_r_nw = !r_is_write;
        if (mem_rdy) w_state_next = r_is_write ? ST_IDLE : ST_EXEC;
      end
      ST_EXEC: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_b       = (r_mode == MODE_IMM) ? r_imm : r_mdata;
  assign w_alu_sub = (r_op != OP_ADC);
  assign w_alu_cin = (r_op == OP_CMP) ? 1'b1 : r_p[c_flag_c];
  assign w_alu_dec = r_p[c_flag_d] && (r_op != OP_CMP);

  cpu_exec_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_a          (r_ac),
    .i_b          (w_b),
    .i_cin        (w_alu_cin),
    .i_sub        (w_alu_sub),
    .i_dec        (w_alu_dec),
    .o_result     (w_alu_res),
    .o_bin_result (w_alu_bin),
    .o_c          (w_alu_c),
    .o_v          (w_alu_v)
  );

  // Execute-stage result selection and flag update
  always_comb begin
    w_ac_we   = 1'b0;
    w_ac_new  = r_ac;
    w_idx_we  = 1'b0;
    w_idx_new = w_reg_val;
    w_p_new   = r_p;
    w_zn_we   = 1'b0;
    w_zn_val  = '0;
    case (r_op)
      OP_LDA: begin w_ac_we = 1'b1;  w_ac_new = w_b;  w_zn_we = 1'b1; w_zn_val = w_b; end
      OP_LDX: begin w_idx_we = 1'b1; w_idx_new = w_b; w_zn_we = 1'b1; w_zn_val = w_b; end
      OP_ADC, OP_SBC: begin
        w_ac_we = 1'b1;
        w_ac_new = w_alu_res;
        w_p_new[c_flag_c] = w_alu_c;
        w_p_new[c_flag_v] = w_alu_v;
        w_zn_we = 1'b1;
        w_zn_val = w_alu_bin;
      end
      OP_AND: begin w_ac_we = 1'b1; w_ac_new = r_ac & w_b; w_zn_we = 1'b1; w_zn_val = r_ac & w_b; end
      OP_ORA: begin w_ac_we = 1'b1; w_ac_new = r_ac | w_b; w_zn_we = 1'b1; w_zn_val = r_ac | w_b; end
      OP_EOR: begin w_ac_we = 1'b1; w_ac_new = r_ac ^ w_b; w_zn_we = 1'b1; w_zn_val = r_ac ^ w_b; end
      OP_CMP: begin
        w_p_new[c_flag_c] = w_alu_c;
        w_zn_we = 1'b1;
        w_zn_val = w_alu_bin;
      end
      OP_INX: begin w_idx_we = 1'b1; w_idx_new = w_reg_val + 1'b1; w_zn_we = 1'b1; w_zn_val = w_reg_val + 1'b1; end
      OP_DEX: begin w_idx_we = 1'b1; w_idx_new = w_reg_val - 1'b1; w_zn_we = 1'b1; w_zn_val = w_reg_val - 1'b1; end
      OP_TAX: begin w_idx_we = 1'b1; w_idx_new = r_ac; w_zn_we = 1'b1; w_zn_val = r_ac; end
      OP_TXA: begin w_ac_we = 1'b1; w_ac_new = w_reg_val; w_zn_we = 1'b1; w_zn_val = w_reg_val; end
      OP_FLG: begin
        if (r_imm[1]) w_p_new[c_flag_d] = r_imm[0];
        else          w_p_new[c_flag_c] = r_imm[0];
      end
      default: ;
    endcase
    if (w_zn_we) begin
      w_p_new[c_flag_z] = (w_zn_val == '0);
      w_p_new[c_flag_n] = w_zn_val[DATA_W-1];
    end
  end

  // Datapath registers: micro-op capture, bus address/data, write-back
  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      r_ac       <= '0;
      r_p        <= 8'h00;
      r_op       <= OP_NOP;
      r_mode     <= MODE_IMM;
      r_reg      <= '0;
      r_imm      <= '0;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mdata    <= '0;
      r_done     <= 1'b0;
      for (int i = 0; i < NUM_IDX; i++) r_idx[i] <= '0;
    end else begin
      r_done <= (r_state == ST_EXEC) || ((r_state == ST_MEM) && r_is_write && mem_rdy);
      if (w_accept) begin
        r_op       <= w_in_op;
        r_mode     <= w_in_mode;
        r_reg      <= uop_reg;
        r_imm      <= uop_operand[DATA_W-1:0];
        r_is_write <= w_in_store && w_in_bus;
        if (w_in_bus) r_addr <= w_in_addr;
        if (w_in_store && w_in_bus) r_wdata <= (w_in_op == OP_STA) ? r_ac : w_sreg_val;
      end
      if (r_state == ST_FIX)
        r_addr[ADDR_W-1:DATA_W] <= r_addr[ADDR_W-1:DATA_W] + {{(c_hi_w-1){1'b0}}, 1'b1};
      if ((r_state == ST_MEM) && !r_is_write && mem_rdy)
        r_mdata <= mem_rdata;
      if (r_state == ST_EXEC) begin
        if (w_ac_we) r_ac <= w_ac_new;
        for (int i = 0; i < NUM_IDX; i++)
          if (w_idx_we && (i == int'(r_reg))) r_idx[i] <= w_idx_new;
        r_p <= w_p_new;
      end
    end
  end

  assign done_valid = r_done;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign ac_dbg     = r_ac;
  assign p_dbg      = r_p;
  assign state_dbg  = r_state;

  for (genvar g = 0; g < NUM_IDX; g++) begin : g_idx_dbg
    assign idx_dbg[g*DATA_W +: DATA_W] = r_idx[g];
  end

endmodule
`default_nettype wire
